// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - store buffer bus: store intake, memory drain, load forwarding probe, status
interface store_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) ();
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;

    logic              mem_wr_valid;
    logic              mem_wr_ready;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_data;

    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic [31:0]       ld_data;

    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;

    // Execute stage / memory / load unit side
    modport master (
        output st_valid, st_addr, st_data, mem_wr_ready, ld_addr,
        input  st_ready, mem_wr_valid, mem_wr_addr, mem_wr_data,
               ld_hit, ld_data, count, empty, full
    );

    // Store buffer side
    modport slave (
        input  st_valid, st_addr, st_data, mem_wr_ready, ld_addr,
        output st_ready, mem_wr_valid, mem_wr_addr, mem_wr_data,
               ld_hit, ld_data, count, empty, full
    );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store queue to data memory; load forwarding enabled by STORE_BUFFER_FWD_EN
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    store_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [31:0]       data_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic empty_w;
    logic full_w;
    logic push;
    logic pop;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    // Status comes only from registered occupancy, so there is no path from the handshakes.
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CNT_W'(DEPTH));

    // A full buffer refuses stores even when the head drains this cycle.
    assign push = bus.st_valid && !full_w;
    assign pop  = bus.mem_wr_ready && !empty_w;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            addr_d[wr_ptr_q] = bus.st_addr;
            data_d[wr_ptr_q] = bus.st_data;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // State registers; reset discards every pending store
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    logic [1:0] unused_ld_lo;
    assign unused_ld_lo = bus.ld_addr[1:0];

    // Scan oldest to youngest so the youngest word match overrides older ones
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) &&
                (addr_q[rd_ptr_q + PTR_W'(i)][ADDR_W-1:2] == bus.ld_addr[ADDR_W-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[rd_ptr_q + PTR_W'(i)];
            end
        end
    end
`else
    logic [ADDR_W-1:0] unused_ld;
    assign unused_ld = bus.ld_addr;
    assign fwd_hit   = 1'b0;
    assign fwd_data  = '0;
`endif

    assign bus.st_ready     = !full_w;
    assign bus.mem_wr_valid = !empty_w;
    assign bus.mem_wr_addr  = empty_w ? '0 : addr_q[rd_ptr_q];
    assign bus.mem_wr_data  = empty_w ? '0 : data_q[rd_ptr_q];
    assign bus.ld_hit       = fwd_hit;
    assign bus.ld_data      = fwd_data;
    assign bus.count        = count_q;
    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
endmodule

// File: doc/store_buffer.md
# store_buffer

Buffers completed store operations between the memory-write data selection stage and the data-memory write port. Each accepted store is an address plus a 32-bit word, already selected between general-register data and converted XMM data. Stores are queued in order and drained to memory through a valid/ready handshake, so the execute stage does not stall on memory back-pressure until the queue fills. An optional forwarding path lets loads see the youngest pending store to the same word.

## Interface
- DEPTH, 4, number of queue entries; power of two, minimum 2
- ADDR_W, 32, byte-address width
- clk  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- st_valid  in  1  store request from execute
- st_ready  out  1  buffer can accept a store this cycle
- st_addr  in  ADDR_W  store byte address
- st_data  in  32  store word from the memory-write data mux
- mem_wr_valid  out  1  head entry presented to data memory
- mem_wr_ready  in  1  data memory accepts the head entry
- mem_wr_addr  out  ADDR_W  head entry address
- mem_wr_data  out  32  head entry data
- ld_addr  in  ADDR_W  load address probed for forwarding
- ld_hit  out  1  a pending store matches ld_addr
- ld_data  out  32  data of the youngest matching pending store
- count  out  $clog2(DEPTH+1)  number of occupied entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH

## Operation
- Circular FIFO: storage arrays addr[DEPTH] and data[DEPTH], wr_ptr and rd_ptr of width $clog2(DEPTH), and a separate occupancy counter.
- Push: st_valid && st_ready writes {st_addr, st_data} at wr_ptr. wr_ptr increments and wraps from DEPTH-1 to 0.
- Pop: mem_wr_valid && mem_wr_ready advances rd_ptr, which wraps in the same way.
- Push and pop in the same cycle: both pointers advance and count is unchanged.
- st_ready = !full. A store offered while the buffer is full is not accepted, even if a pop happens in the same cycle; there is no pass-through.
- mem_wr_valid = !empty. mem_wr_addr and mem_wr_data are read combinationally from rd_ptr. While the head waits for mem_wr_ready, these outputs hold stable until it is accepted.
- Ordering is strict FIFO. Memory sees stores in acceptance order.
- The data word is stored verbatim. This block applies no byte enables and no format conversion.
- Illegal push/pop (push when full, pop when empty) cannot occur because of the gating above. The verification engineer asserts that count never exceeds DEPTH and never underflows.

## Timing
- Reset (reset_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0. Resulting outputs: empty=1, full=0, st_ready=1, mem_wr_valid=0, ld_hit=0. mem_wr_addr, mem_wr_data and ld_data are driven to 0 while empty.
- Reset asserted mid-operation discards all pending stores. Deassertion takes effect at the first clk edge.
- Latency: a store pushed at edge N is visible on mem_wr_* after edge N (first cycle N+1). Empty-to-memory latency is 1 cycle.
- Throughput: one push and one pop per cycle sustained.
- full deasserts in the cycle after a pop that occurs without a push. st_ready follows.
- count, empty and full are registered-state derived. They take no combinational path from st_valid or mem_wr_ready.

## Configuration
- STORE_BUFFER_FWD_EN defined:
  - Each cycle, ld_addr[ADDR_W-1:2] is compared against every occupied entry's addr[ADDR_W-1:2].
  - ld_hit=1 if any entry matches. ld_data is taken from the youngest match, i.e. the one closest to wr_ptr-1.
  - The path is purely combinational and reflects state after the last edge. It does not include a store being pushed in the same cycle.
- STORE_BUFFER_FWD_EN not defined:
  - ld_hit is tied to 0 and ld_data to 0. The ports remain so the interface is fixed.
  - No comparators are built, so the load path must wait for empty instead.

## Test plan
- Reset then idle → empty=1, st_ready=1, mem_wr_valid=0, count=0 for 10 cycles.
- Push addr 0x100/data 0xDEADBEEF with mem_wr_ready=1 → mem_wr_valid=1 for exactly 1 cycle, one cycle after the push, with mem_wr_addr=0x100 and mem_wr_data=0xDEADBEEF. Then empty=1.
- mem_wr_ready=0, push DEPTH=4 stores (0x10..0x13 data 1..4), offer a 5th → full=1, st_ready=0, 5th not accepted. Then release ready → memory receives data 1,2,3,4 in order, with outputs stable while stalled.
- Hold full, assert st_valid and mem_wr_ready together → pop occurs, push rejected, count 3. Next cycle, push accepted and count 4.
- Continuous push/pop for 3×DEPTH cycles → pointers wrap correctly, count constant at 1, and the data sequence is preserved.
- With STORE_BUFFER_FWD_EN: queue 0x200→0xA, 0x204→0xB, 0x200→0xC with memory stalled, set ld_addr=0x202 → ld_hit=1, ld_data=0xC. With ld_addr=0x300 → ld_hit=0. Without the macro → ld_hit=0 in all cases.
